decoder_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 3-to-8 decoded select resource among 8 requesters.
- Each cycle the winning requester's 3-bit index is registered and decoded into a one-hot grant vector, which drives downstream enables.
- Grant holds until the owner releases it, drops its request, or hits a hold timeout.
- Sits between requesting units and the decoder-driven shared bus/enable lines.

---
 rtl/decoder_rr_arbiter_if.sv | 22 ++
 rtl/decoder_rr_arbiter.sv | 111 +++++++++++
 tb/tb_decoder_rr_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesting units and the round-robin
// arbiter that owns the shared 3-to-8 decoded enable lines.
interface decoder_rr_arbiter_if;
  logic [7:0] req;          // bit i = requester i wants the resource
  logic       done;         // owner release pulse, meaningful only while granted
  logic [7:0] grant;        // one-hot enable for the current owner, else zero
  logic [2:0] grant_idx;    // encoded owner, qualify with grant_valid
  logic       grant_valid;  // a grant is currently held
  logic       timeout;      // grant was revoked by the hold limit

  // Requesting side: drives requests and release, observes the grant.
  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing one decoded select
// resource. The winner's index is registered and decoded to a one-hot grant.
// A grant is held until the owner pulses done, drops its request, or has
// held for MAX_HOLD cycles; one dead cycle always separates two grants and
// the search pointer moves just past the previous owner for fairness.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 12,  // legal range 1..15
  parameter int unsigned CNT_W    = 4    // 2**CNT_W must exceed MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_rr_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counter value seen during the last cycle an owner is allowed to hold.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [2:0]       ptr;
  logic [2:0]       grant_idx_q;
  logic [7:0]       grant_q;
  logic             grant_valid_q;
  logic             timeout_q;
  logic [CNT_W-1:0] hold_cnt;

  logic [2:0]       winner;
  logic [2:0]       cand;
  logic             owner_req;
  logic             at_limit;
  logic             release_now;

  // Pick the first requester at or after ptr, wrapping modulo 8. Scanning
  // from the far end downwards lets the nearest candidate overwrite the rest.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (bus.req[cand]) begin
        winner = cand;
      end
    end
  end

  assign owner_req   = bus.req[grant_idx_q];
  assign at_limit    = (hold_cnt == HOLD_LAST);
  assign release_now = bus.done | ~owner_req | at_limit;

  // Arbitration state machine; every output is a register.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values and simulation matches hardware.
  // NOTE: every register here is a control flop, so all of them take the
  // asynchronous reset and an active grant is dropped the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 3'd0;
      grant_idx_q   <= 3'd0;
      grant_q       <= 8'h00;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      hold_cnt      <= '0;
    end else begin
      // The timeout flag only survives the single cycle after its release.
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          // done is ignored here; only requests start a new grant.
          if (|bus.req) begin
            grant_idx_q   <= winner;
            grant_q       <= 8'b1 << winner;
            grant_valid_q <= 1'b1;
            hold_cnt      <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          // Non-owner requests are ignored until the next IDLE evaluation.
          if (release_now) begin
            state         <= IDLE;
            grant_q       <= 8'h00;
            grant_valid_q <= 1'b0;
            ptr           <= grant_idx_q + 3'd1;
            // Flag only releases forced purely by the hold limit.
            timeout_q     <= at_limit & ~bus.done & owner_req;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          grant_q       <= 8'h00;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter. A reference model advances on
// every rising edge and queues the expected outputs; an independent monitor
// pops and compares on every falling edge. Directed scenarios are followed
// by a long randomized run.
module tb_decoder_rr_arbiter;

  localparam int MAX_HOLD = 12;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  decoder_rr_arbiter_if bus ();

  decoder_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: owner is -1 when nobody holds the resource, held
  // counts the cycles the owner has had the grant so far (1-based).
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];

  int m_owner;
  int m_held;
  int m_ptr;
  int m_last;

  function automatic void reset_model();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_last  = 0;
  endfunction

  function automatic exp_t model_out(input bit to);
    exp_t e;
    e.valid   = (m_owner >= 0);
    e.idx     = e.valid ? 3'(m_owner) : 3'(m_last);
    e.grant   = e.valid ? 8'(1 << m_owner) : 8'h00;
    e.timeout = to;
    return e;
  endfunction

  // Advance the model with the inputs present at this rising edge.
  always @(posedge clk) begin
    bit to;
    bit hit;
    bit found;
    int c;
    to = 1'b0;
    if (!rst_n) begin
      reset_model();
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        c = (m_ptr + k) % 8;
        if (!found && bus.req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_held  = 1;
        end
      end
    end else begin
      hit = (m_held == MAX_HOLD);
      if (bus.done || !bus.req[m_owner] || hit) begin
        to      = hit && !bus.done && bus.req[m_owner];
        m_ptr   = (m_owner + 1) % 8;
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
    exp_q.push_back(model_out(to));
  end

  // An asynchronous reset overrides whatever was expected for this cycle.
  always @(negedge rst_n) begin
    reset_model();
    if (exp_q.size() > 0) exp_q[0] = model_out(1'b0);
  end

  // ---------------------------------------------------------------------
  // Monitor: compare every falling edge against the queued expectation.
  // ---------------------------------------------------------------------
  exp_t mon_e;
  int   run_len = 0;

  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      mon_e = exp_q.pop_front();
      check("grant",       bus.grant,       mon_e.grant);
      check("grant_idx",   bus.grant_idx,   mon_e.idx);
      check("grant_valid", bus.grant_valid, mon_e.valid);
      check("timeout",     bus.timeout,     mon_e.timeout);
    end
    check("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
    if (bus.grant_valid === 1'b1) begin
      run_len++;
    end else begin
      if (bus.timeout === 1'b1) check("timeout_hold_len", run_len, MAX_HOLD);
      run_len = 0;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------
  task automatic drive(input logic [7:0] r, input logic d);
    @(posedge clk);
    #1;
    bus.req  = r;
    bus.done = d;
  endtask

  task automatic wait_valid(input logic v, input int max_cycles);
    int n;
    n = 0;
    while (bus.grant_valid !== v && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_grant_valid", bus.grant_valid, v);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] rot_exp [7];
  logic [7:0] r;
  logic       d;

  initial begin
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    rot_exp  = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h80, 8'h00, 8'h01};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Async reset mid-grant, then first grant goes to requester 0.
    drive(8'hFF, 1'b0);
    wait_valid(1'b1, 4);
    drive(8'hFF, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_grant",       bus.grant,       8'h00);
    check("rst_grant_valid", bus.grant_valid, 1'b0);
    check("rst_timeout",     bus.timeout,     1'b0);
    check("rst_grant_idx",   bus.grant_idx,   3'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_valid(1'b1, 4);
    check("rst_first_grant", bus.grant, 8'h01);
    drive(8'h00, 1'b0);
    wait_valid(1'b0, 4);

    // Single requester, done on the third BUSY cycle.
    drive(8'h04, 1'b0);
    wait_valid(1'b1, 4);
    check("single_grant", bus.grant, 8'h04);
    check("single_idx",   bus.grant_idx, 3'd2);
    drive(8'h04, 1'b0);
    drive(8'h04, 1'b1);
    drive(8'h0C, 1'b0);
    check("single_release", bus.grant_valid, 1'b0);
    wait_valid(1'b1, 4);
    check("single_ptr_next", bus.grant_idx, 3'd3);
    drive(8'h00, 1'b0);
    wait_valid(1'b0, 4);

    // Round-robin rotation with wrap from 7 to 0.
    do_reset();
    drive(8'h83, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(8'h83, 1'b1);
      check("rotation", bus.grant, rot_exp[i]);
    end
    drive(8'h00, 1'b0);
    wait_valid(1'b0, 4);

    // Hold-limit timeout with the request kept high.
    repeat (30) drive(8'h10, 1'b0);
    drive(8'h00, 1'b0);
    wait_valid(1'b0, 4);

    // Owner drops its request; pending requester 6 follows.
    drive(8'h60, 1'b0);
    wait_valid(1'b1, 4);
    check("drop_owner", bus.grant_idx, 3'd5);
    drive(8'h40, 1'b0);
    drive(8'h40, 1'b0);
    check("drop_dead_valid", bus.grant_valid, 1'b0);
    check("drop_timeout",    bus.timeout,     1'b0);
    drive(8'h40, 1'b0);
    check("drop_next_grant", bus.grant, 8'h40);
    drive(8'h00, 1'b0);
    wait_valid(1'b0, 4);

    // done and request drop coinciding with hold-limit expiry.
    drive(8'h08, 1'b0);
    wait_valid(1'b1, 4);
    repeat (10) drive(8'h08, 1'b0);
    drive(8'h01, 1'b1);
    drive(8'h01, 1'b0);
    check("coincide_dead",    bus.grant_valid, 1'b0);
    check("coincide_timeout", bus.timeout,     1'b0);
    drive(8'h01, 1'b0);
    check("coincide_next", bus.grant, 8'h01);
    drive(8'h00, 1'b0);
    wait_valid(1'b0, 4);

    // Randomized traffic: requests change occasionally so holds get long.
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) r = 8'($urandom);
      d = ($urandom_range(0, 7) == 0);
      if (i == 1500) do_reset();
      else drive(r, d);
    end

    repeat (3) drive(8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
